// File: rtl/axi_lite_dmem_master_if.sv
// AXI4-Lite bus bundle between the dmem master bridge and the memory wrapper's dmem slave.
interface axi_lite_dmem_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   ARADDR;
    logic                ARVALID;
    logic                ARREADY;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RVALID;
    logic                RREADY;
    logic [ADDR_W-1:0]   AWADDR;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    modport master (
        output ARADDR, ARVALID, input  ARREADY,
        input  RDATA, RRESP, RVALID, output RREADY,
        output AWADDR, AWVALID, input  AWREADY,
        output WDATA, WSTRB, WVALID, input  WREADY,
        input  BRESP, BVALID, output BREADY
    );

    modport slave (
        input  ARADDR, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input  RREADY,
        input  AWADDR, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input  BREADY
    );
endinterface

// File: rtl/axi_lite_dmem_master.sv
// Bridges one core load/store request at a time into a single AXI4-Lite read or write transaction.
module axi_lite_dmem_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   wstrb_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [DATA_W-1:0]     rdata_o,
    axi_lite_dmem_master_if.master axi
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;

    logic [2:0]          state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                arvalid_q;
    logic                rready_q;
    logic                awvalid_q;
    logic                wvalid_q;
    logic                bready_q;
    logic                done_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                wr_both_done;

    // A channel counts as finished if it already dropped VALID or handshakes now.
    assign wr_both_done = (!awvalid_q || axi.AWREADY) && (!wvalid_q || axi.WREADY);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        wstrb_q <= wstrb_i;
                        if (we_i) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (axi.ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (axi.RVALID) begin
                        rdata_q  <= axi.RDATA;
                        err_q    <= (axi.RRESP != 2'b00);
                        done_q   <= 1'b1;
                        rready_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                WR_REQ: begin
                    if (axi.AWREADY) awvalid_q <= 1'b0;
                    if (axi.WREADY)  wvalid_q  <= 1'b0;
                    if (wr_both_done) begin
                        bready_q <= 1'b1;
                        state    <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axi.BVALID) begin
                        err_q    <= (axi.BRESP != 2'b00);
                        done_q   <= 1'b1;
                        bready_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign axi.ARADDR  = addr_q;
    assign axi.ARVALID = arvalid_q;
    assign axi.RREADY  = rready_q;
    assign axi.AWADDR  = addr_q;
    assign axi.AWVALID = awvalid_q;
    assign axi.WDATA   = wdata_q;
    assign axi.WSTRB   = wstrb_q;
    assign axi.WVALID  = wvalid_q;
    assign axi.BREADY  = bready_q;

    assign busy_o  = (state != IDLE);
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;

endmodule
